stage_id_q: RTL
===============

# stage_id_q

Parametrised decode stage with a DEPTH-entry instruction queue, valid/ready handshakes on both sides, an XLEN-configurable RV32I/RV64I decoder, an integrated 32-entry register file with write-back bypass, and a load-use interlock. It sits between fetch and execute and replaces the always-ready, single-slot decode stage. Fetch pushes {pc, instr}; the head entry is decoded in place and issued to execute with operands already read.

## Interface
- XLEN, 64: datapath width. Legal values are 32 or 64. At 32, OPIMM32/OP32/LWU/LD/SD decode as reserved (ri).
- DEPTH, 2: queue entries. Must be a power of two, ≥2.
- clk in 1: clock, rising edge.
- rst in 1: reset. Asynchronous, active-low.
- id_flush in 1: synchronous queue flush.
- in_valid in 1: fetch offers an entry.
- in_ready out 1: queue can accept an entry (!full).
- in_pc in XLEN: pc of the offered instruction.
- in_instr in 32: instruction word.
- out_valid out 1: decoded head entry is valid and not stalled.
- out_ready in 1: execute accepts the head entry.
- out_pc out XLEN: pc of the head entry.
- out_rs1, out_rs2, out_rd out 5 each: register indices from instr[19:15], [24:20], [11:7].
- out_imm out XLEN: selected immediate.
- out_rs1_data, out_rs2_data out XLEN: operands with write-back bypass applied.
- out_ctrl out 16: packed control fields.
  - [3:0] alu_ctrl; [4] alu_imm; [5] alu_pc; [6] alu_32; [7] jump; [8] jalr; [9] branch.
  - [10] mem_read; [11] mem_write; [12] rs1_en; [13] rs2_en; [14] rd_en; [15] ri.
- occupancy out $clog2(DEPTH)+1: number of valid entries.
- wb_en in 1: register-file write enable.
- wb_rd in 5: write-back destination index.
- wb_data in XLEN: write-back data.
- exe_ld_valid in 1: execute currently holds a load.
- exe_ld_rd in 5: destination of that load.

## Operation
- Queue storage:
  - Circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits each, wrapping modulo DEPTH, plus a count register.
  - push = in_valid && in_ready && !id_flush.
  - pop = out_valid && out_ready.
  - Push and pop may occur in the same cycle; count is then unchanged.
- in_ready = (count != DEPTH). At full, no push is accepted even when a pop occurs in the same cycle.
- Decode is combinational from the head entry. Field values by opcode:
  - LUI: alu_ctrl=1111, alu_imm, rd_en; imm U-type sign-extended to XLEN.
  - AUIPC: alu_ctrl=0000, alu_pc, alu_imm, rd_en; imm U-type.
  - JAL: jump, rd_en; imm J-type.
  - JALR: jump, jalr, rs1_en, rd_en; imm I-type.
  - BRANCH: branch, rs1_en, rs2_en; imm B-type.
  - LOAD: mem_read, alu_imm, rs1_en, rd_en; imm I-type. funct3 011 (LD) and 110 (LWU) are legal only when XLEN=64; funct3 111 is always ri.
  - STORE: mem_write, alu_imm, rs1_en, rs2_en; imm S-type. funct3 ≥100 is ri; 011 (SD) is ri when XLEN=32.
  - OPIMM, shifts (funct3 001/101):
    - alu_ctrl = {instr[30], funct3}.
    - imm = zero-extended shamt: 6 bits when XLEN=64, 5 bits when XLEN=32.
    - ri if the upper funct bits are not 0 (or 0100000 for SRAI). When XLEN=32, instr[25]=1 is ri.
  - OPIMM, other funct3: alu_ctrl = {0, funct3}; imm I-type.
  - OPIMM32: alu_32 set; only funct3 000/001/101 are legal; shamt is 5 bits.
  - OP: alu_ctrl = {instr[30], funct3}. funct7 must be 0000000; 0100000 is also legal for funct3 000 and 101. Anything else is ri.
  - OP32: same funct7 rules as OP, alu_32 set, funct3 restricted to 000/001/101.
  - Unknown opcode: ri=1, all other fields 0, imm=0.
- rd_en = |rd, so writes to x0 are never enabled.
- ri entries still issue normally; trap handling happens downstream.
- Register file: 32×XLEN; x0 reads 0 and ignores writes. Write occurs at the clock edge when wb_en && wb_rd != 0.
- Bypass: if wb_en && wb_rd != 0 && wb_rd == out_rsN, then out_rsN_data = wb_data.
- Load-use interlock:
  - hazard = exe_ld_valid && exe_ld_rd != 0 && ((rs1_en && rs1 == exe_ld_rd) || (rs2_en && rs2 == exe_ld_rd)).
  - out_valid = (count != 0) && !hazard && !id_flush.
- Flush: on an edge with id_flush=1, count, wr_ptr and rd_ptr all go to 0. Any push or pop presented in that cycle is discarded. Register-file writes still occur.

## Timing
- Reset (rst low, asynchronous):
  - count, pointers and occupancy = 0; in_ready = 1; out_valid = 0; all register-file entries = 0.
  - Reset asserted mid-operation drops all queued entries immediately.
- Latency: an entry pushed at edge N drives out_valid at N+1. There is no combinational in→out path.
- out_* fields are combinational from the queue head, the register file, wb_* and exe_ld_*.
- in_ready depends only on registered state.
- While out_valid=1 && out_ready=0, all out_* fields hold stable, unless wb bypass data changes.
- Write-back at edge N is visible both via bypass in cycle N and via the register file from N+1.

## Test plan
- Reset, then push `addi x1,x0,5` (0x00500093) at pc 0x1000 → next cycle: out_valid=1, imm=5, out_ctrl: alu_imm, rs1_en, rd_en set, alu_ctrl=0000, ri=0.
- DEPTH=2 with out_ready=0: push 3 entries → third not accepted (in_ready=0 after 2 pushes), occupancy=2. Then pop and push in the same cycle ×8 → FIFO order is preserved across pointer wrap.
- wb_en=1, wb_rd=3, wb_data=0xDEAD with head `add x4,x3,x3` → out_rs1_data = out_rs2_data = 0xDEAD in the same cycle. Next cycle with wb_en=0 the values are still 0xDEAD.
- exe_ld_valid=1, exe_ld_rd=5 with head `sub x6,x5,x7` → out_valid=0. Deassert exe_ld_valid → out_valid=1, alu_ctrl=1000. A head with rd=5 but no read of x5 is not stalled.
- XLEN=32: `ld` (0x0000B083), `addiw` and `slli x1,x1,32` each → ri=1. XLEN=64: `slli x1,x1,32` → ri=0, imm=32.
- Queue full with id_flush and in_valid both asserted → next cycle occupancy=0 and out_valid=0; a push after flush issues at the following cycle.

Source files
------------

// File: rtl/stage_id_q_if.sv
// Handshake bundle between fetch, the decode queue and execute.
// A transfer happens on a rising edge where valid && ready are both high; valid never
// depends on ready in the same cycle, and the payload holds while valid && !ready.
interface stage_id_q_if #(
    parameter int XLEN = 64
);
    // fetch -> decode
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    // decode -> execute
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [15:0]     out_ctrl;

    // Environment side: fetch produces entries, execute consumes them.
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_rs1_data, out_rs2_data, out_ctrl
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_rs1_data, out_rs2_data, out_ctrl
    );
endinterface

// File: rtl/stage_id_q.sv
// Decode stage: DEPTH-entry instruction queue, RV32I/RV64I decoder on the head entry,
// 32-entry register file with write-back bypass, and a load-use interlock.
module stage_id_q #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_flush,
    stage_id_q_if.slave            io,
    output logic [$clog2(DEPTH):0] occupancy,
    input  logic                   wb_en,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   exe_ld_valid,
    input  logic [4:0]             exe_ld_rd
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam bit          RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            push;
    logic            pop;
    logic            hazard;

    assign io.in_ready = (count != FULL);
    assign push        = io.in_valid && io.in_ready && !id_flush;
    assign pop         = io.out_valid && io.out_ready;
    assign occupancy   = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (id_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    // Payload storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= io.in_pc;
            q_instr[wr_ptr] <= io.in_instr;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the head entry
    // ------------------------------------------------------------------
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_shamt;
    logic [XLEN-1:0] imm_shamt5;
    logic            op_funct7_ok;
    logic            op32_funct3_ok;

    assign instr  = q_instr[rd_ptr];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // Shift amounts are unsigned; RV64 uses the 6-bit form on full-width shifts.
    assign imm_shamt  = RV64 ? {{(XLEN-6){1'b0}}, instr[25:20]}
                             : {{(XLEN-5){1'b0}}, instr[24:20]};
    assign imm_shamt5 = {{(XLEN-5){1'b0}}, instr[24:20]};

    assign op_funct7_ok   = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign op32_funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101);

    logic [3:0]      alu_ctrl;
    logic            alu_imm;
    logic            alu_pc;
    logic            alu_32;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            rs1_en;
    logic            rs2_en;
    logic            writes_rd;
    logic            rd_en;
    logic            ri;
    logic [XLEN-1:0] imm;

    always_comb begin
        alu_ctrl  = 4'b0000;
        alu_imm   = 1'b0;
        alu_pc    = 1'b0;
        alu_32    = 1'b0;
        jump      = 1'b0;
        jalr      = 1'b0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rs1_en    = 1'b0;
        rs2_en    = 1'b0;
        writes_rd = 1'b0;
        ri        = 1'b0;
        imm       = '0;

        case (opcode)
            OPC_LUI: begin
                alu_ctrl  = 4'b1111;
                alu_imm   = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_u;
            end
            OPC_AUIPC: begin
                alu_pc    = 1'b1;
                alu_imm   = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_u;
            end
            OPC_JAL: begin
                jump      = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_j;
            end
            OPC_JALR: begin
                jump      = 1'b1;
                jalr      = 1'b1;
                rs1_en    = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_BRANCH: begin
                branch = 1'b1;
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                imm    = imm_b;
            end
            OPC_LOAD: begin
                mem_read  = 1'b1;
                alu_imm   = 1'b1;
                rs1_en    = 1'b1;
                writes_rd = 1'b1;
                imm       = imm_i;
                case (funct3)
                    3'b011, 3'b110: ri = !RV64;
                    3'b111:         ri = 1'b1;
                    default:        ri = 1'b0;
                endcase
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                alu_imm   = 1'b1;
                rs1_en    = 1'b1;
                rs2_en    = 1'b1;
                imm       = imm_s;
                ri        = funct3[2] || ((funct3 == 3'b011) && !RV64);
            end
            OPC_OPIMM: begin
                alu_imm   = 1'b1;
                rs1_en    = 1'b1;
                writes_rd = 1'b1;
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    alu_ctrl = {instr[30], funct3};
                    imm      = imm_shamt;
                    if (funct3 == 3'b001) begin
                        ri = (instr[31:26] != 6'b000000);
                    end else begin
                        ri = (instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000);
                    end
                    // RV32 has only a 5-bit shamt, so bit 25 must be clear.
                    if (!RV64 && instr[25]) begin
                        ri = 1'b1;
                    end
                end else begin
                    alu_ctrl = {1'b0, funct3};
                    imm      = imm_i;
                end
            end
            OPC_OPIMM32: begin
                if (RV64) begin
                    alu_imm   = 1'b1;
                    alu_32    = 1'b1;
                    rs1_en    = 1'b1;
                    writes_rd = 1'b1;
                    case (funct3)
                        3'b000: begin
                            alu_ctrl = 4'b0000;
                            imm      = imm_i;
                        end
                        3'b001: begin
                            alu_ctrl = {instr[30], funct3};
                            imm      = imm_shamt5;
                            ri       = (funct7 != 7'b0000000);
                        end
                        3'b101: begin
                            alu_ctrl = {instr[30], funct3};
                            imm      = imm_shamt5;
                            ri       = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                        end
                        default: ri = 1'b1;
                    endcase
                end else begin
                    ri = 1'b1;
                end
            end
            OPC_OP: begin
                alu_ctrl  = {instr[30], funct3};
                rs1_en    = 1'b1;
                rs2_en    = 1'b1;
                writes_rd = 1'b1;
                ri        = !op_funct7_ok;
            end
            OPC_OP32: begin
                if (RV64) begin
                    alu_ctrl  = {instr[30], funct3};
                    alu_32    = 1'b1;
                    rs1_en    = 1'b1;
                    rs2_en    = 1'b1;
                    writes_rd = 1'b1;
                    ri        = !op_funct7_ok || !op32_funct3_ok;
                end else begin
                    ri = 1'b1;
                end
            end
            default: ri = 1'b1;
        endcase
    end

    assign rd_en = writes_rd && (rd != 5'd0);

    // ------------------------------------------------------------------
    // Operand read with write-back bypass, interlock and issue
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic            wb_live;

    assign wb_live = wb_en && (wb_rd != 5'd0);
    assign rs1_rf  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_rf  = (rs2 == 5'd0) ? '0 : regs[rs2];

    assign hazard = exe_ld_valid && (exe_ld_rd != 5'd0) &&
                    ((rs1_en && (rs1 == exe_ld_rd)) || (rs2_en && (rs2 == exe_ld_rd)));

    assign io.out_valid    = (count != '0) && !hazard && !id_flush;
    assign io.out_pc       = q_pc[rd_ptr];
    assign io.out_rs1      = rs1;
    assign io.out_rs2      = rs2;
    assign io.out_rd       = rd;
    assign io.out_imm      = imm;
    assign io.out_rs1_data = (wb_live && (wb_rd == rs1)) ? wb_data : rs1_rf;
    assign io.out_rs2_data = (wb_live && (wb_rd == rs2)) ? wb_data : rs2_rf;
    assign io.out_ctrl     = {ri, rd_en, rs2_en, rs1_en, mem_write, mem_read, branch,
                              jalr, jump, alu_32, alu_pc, alu_imm, alu_ctrl};
endmodule
